// File: rtl/pwm_peripheral.sv
// PWM output stage: prescaled 8-bit period counter, period-boundary duty shadow
// and per-pin force-low / force-high / PWM output selection.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start,
  output logic [7:0]  duty_active
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PINS  = 16;

  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   pwm_cnt;
  logic               tick_c;
  logic               boundary_c;
  logic               pwm_raw_c;
  logic [PINS-1:0]    en_out_c;
  logic [PINS-1:0]    en_pwm_c;

  assign tick_c     = (presc_cnt == PRESC_W'(CLK_DIV - 1));
  assign boundary_c = tick_c && (pwm_cnt == '1);
  // Full scale is special-cased so 0xFF means truly always high.
  assign pwm_raw_c  = (duty_active == 8'hFF) || (pwm_cnt < duty_active);
  assign en_out_c   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_c   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Prescaler: counts 0..CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick_c) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // Period counter wraps naturally 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick_c) begin
      pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end

  // Duty shadow only loads on the period boundary to keep periods glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary_c;
      if (boundary_c) begin
        duty_active <= pwm_duty_cycle;
      end
    end
  end

  // Pin drive: disabled pins low, enabled non-PWM pins high, else shared waveform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= en_out_c & (~en_pwm_c | {PINS{pwm_raw_c}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized self-checking bench for pwm_peripheral against an arithmetic
// model derived from the elapsed clock count since reset release.
module tb_pwm_peripheral;

  localparam int unsigned D = 3;
  localparam int unsigned P = 256 * D;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_active;

  int unsigned checks;
  int unsigned errors;
  int unsigned n;
  logic [7:0]  duty_m;

  pwm_peripheral #(.CLK_DIV(D), .PRESC_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start),
    .duty_active     (duty_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  // Model: after n clocks since release, the counter sits at (n/D)%256 and the
  // shadow holds the duty sampled at the last multiple of the period length.
  task automatic step();
    logic        raw;
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] exp_out;
    int unsigned nn;
    logic        ps;
    logic [7:0]  dn;
    eo      = {en_reg_out_15_8, en_reg_out_7_0};
    ep      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    raw     = (duty_m == 8'hFF) || (((n / D) % 256) < 32'(duty_m));
    exp_out = eo & (~ep | {16{raw}});
    nn      = n + 1;
    ps      = ((nn % P) == 0);
    dn      = ps ? pwm_duty_cycle : duty_m;
    @(posedge clk);
    #1;
    n      = nn;
    duty_m = dn;
    check("out", out, exp_out);
    check("period_start", 16'(period_start), 16'(ps));
    check("duty_active", 16'(duty_active), 16'(dn));
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic hold_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out", out, 16'h0000);
    check("rst_async_duty", 16'(duty_active), 16'h0000);
    check("rst_async_ps", 16'(period_start), 16'h0000);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold_out", out, 16'h0000);
      check("rst_hold_duty", 16'(duty_active), 16'h0000);
      check("rst_hold_ps", 16'(period_start), 16'h0000);
    end
    rst_n  = 1'b1;
    n      = 0;
    duty_m = 8'h00;
  endtask

  function automatic logic [7:0] pick_duty();
    case ($urandom_range(5))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h7F;
      3:       return 8'hFE;
      4:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Random enables occasionally; duty writes at random times and often on the boundary edge.
  task automatic random_steps(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      if ($urandom_range(63) == 0) begin
        if ($urandom_range(2) == 0) set_en(16'hFFFF, 16'hFFFF);
        else set_en(16'($urandom), 16'($urandom));
      end
      if ($urandom_range(399) == 0 || (((n + 1) % P) == 0 && $urandom_range(1) == 0)) begin
        pwm_duty_cycle = pick_duty();
      end
      step();
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b1;
    checks = 0;
    errors = 0;
    n      = 0;
    duty_m = 8'h00;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    @(posedge clk);
    #1;
    hold_reset(20);

    // Static modes, then disable overrides PWM select.
    set_en(16'hA5C3, 16'h0000);
    step();
    step();
    set_en(16'h0000, 16'hFFFF);
    step();

    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h20;
    random_steps(4 * P);

    // Drive pins statically high, then reset at counter value 100.
    set_en(16'hFFFF, 16'h0000);
    for (int unsigned i = 0; i < P && ((n / D) % 256) != 100; i++) step();
    check("reached_cnt100", 16'((n / D) % 256), 16'd100);
    hold_reset(4);

    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hC0;
    random_steps(3 * P);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
